// File: rtl/adcdac_2g_spi_master_if.sv
// Control-port bundle between the register side and the board SPI master.
// Ports: start/wr_data request a transfer, busy/done/rd_data report status,
//        user_spi_clk/ss/din/dout are the board SPI lines.
interface adcdac_2g_spi_master_if #(
  parameter int WORD_BITS = 24
);
  logic                 start;
  logic [WORD_BITS-1:0] wr_data;
  logic                 busy;
  logic                 done;
  logic [WORD_BITS-1:0] rd_data;
  logic                 user_spi_clk;
  logic                 user_spi_ss;
  logic                 user_spi_din;
  logic                 user_spi_dout;

  // Requester / board side: issues words and drives MISO.
  modport master (
    output start, wr_data, user_spi_dout,
    input  busy, done, rd_data, user_spi_clk, user_spi_ss, user_spi_din
  );

  // The SPI master block itself.
  modport slave (
    input  start, wr_data, user_spi_dout,
    output busy, done, rd_data, user_spi_clk, user_spi_ss, user_spi_din
  );
endinterface

// File: rtl/adcdac_2g_spi_master.sv
// Purpose: SPI mode-0 master for the ADC/DAC 2G board control port, MSB first, SS active low.
// Latency: busy for (2*WORD_BITS+3)*CLK_DIV cycles after an accepted start, then a 1-cycle done.
// Backpressure: start is accepted only while busy=0 (including the done cycle); no queueing.
// Ports: fpga_clk, rst (sync, active high), bus (slave modport: start/wr_data in,
//        busy/done/rd_data out, user_spi_clk/ss/din out, user_spi_dout in).
// Option: define ADCDAC_SPI_READBACK_EN to capture user_spi_dout into rd_data;
//         otherwise rd_data is tied to 0 and user_spi_dout is ignored.
module adcdac_2g_spi_master #(
  parameter int CLK_DIV   = 8,
  parameter int WORD_BITS = 24
) (
  input  logic                          fpga_clk,
  input  logic                          rst,
  adcdac_2g_spi_master_if.slave         bus
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(WORD_BITS + 1);
  localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LOAD = BW'(WORD_BITS);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t               state, state_nxt;
  logic [DW-1:0]        div_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [WORD_BITS-1:0] tx_sr;

  logic busy_q, done_q, sclk_q, ss_q, din_q;
  logic busy_nxt, done_nxt, sclk_nxt, ss_nxt, din_nxt;

  logic phase_end;
  logic accept;
  logic sclk_fall;

  assign phase_end = (div_cnt == '0);
  assign accept    = (state == IDLE) && bus.start;
  // Falling SCLK inside SHIFT: end of a bit's high phase.
  assign sclk_fall = (state == SHIFT) && phase_end && sclk_q;

  // State register
  always_ff @(posedge fpga_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SETUP;
      SETUP:   if (phase_end) state_nxt = SHIFT;
      // Leave SHIFT only at the end of a low phase with no bits left.
      SHIFT:   if (phase_end && !sclk_q && (bit_cnt == '0)) state_nxt = HOLD;
      HOLD:    if (phase_end) state_nxt = GAP;
      GAP:     if (phase_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs, so the pins
  // never see a combinational path.
  always_comb begin
    busy_nxt = busy_q;
    done_nxt = 1'b0;
    sclk_nxt = sclk_q;
    ss_nxt   = ss_q;
    din_nxt  = din_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          busy_nxt = 1'b1;
          ss_nxt   = 1'b0;
          sclk_nxt = 1'b0;
          din_nxt  = bus.wr_data[WORD_BITS-1];
        end
      end
      SETUP: begin
        if (phase_end) sclk_nxt = 1'b1;
      end
      SHIFT: begin
        if (phase_end) begin
          if (sclk_q) begin
            sclk_nxt = 1'b0;
            // The last bit stays on din through HOLD.
            if (bit_cnt > BW'(1)) din_nxt = tx_sr[WORD_BITS-1];
          end else if (bit_cnt != '0) begin
            sclk_nxt = 1'b1;
          end
        end
      end
      HOLD: begin
        if (phase_end) begin
          ss_nxt  = 1'b1;
          din_nxt = 1'b0;
        end
      end
      GAP: begin
        if (phase_end) begin
          busy_nxt = 1'b0;
          done_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output registers, divider, bit counter and transmit shifter
  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      ss_q    <= 1'b1;
      din_q   <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
    end else begin
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      sclk_q <= sclk_nxt;
      ss_q   <= ss_nxt;
      din_q  <= din_nxt;

      if (accept || ((state != IDLE) && phase_end)) div_cnt <= DIV_LOAD;
      else if (state != IDLE)                       div_cnt <= div_cnt - DW'(1);

      if (accept)                               bit_cnt <= BIT_LOAD;
      else if (sclk_fall && (bit_cnt != '0))    bit_cnt <= bit_cnt - BW'(1);

      // MSB goes straight to din on accept; the shifter holds the rest.
      if (accept)                               tx_sr <= {bus.wr_data[WORD_BITS-2:0], 1'b0};
      else if (sclk_fall && (bit_cnt > BW'(1))) tx_sr <= {tx_sr[WORD_BITS-2:0], 1'b0};
    end
  end

`ifdef ADCDAC_SPI_READBACK_EN
  logic [WORD_BITS-1:0] rx_sr;
  logic [WORD_BITS-1:0] rd_q;

  // Sample MISO on the same edge that raises SCLK.
  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      rx_sr <= '0;
      rd_q  <= '0;
    end else begin
      if (sclk_nxt && !sclk_q) rx_sr <= {rx_sr[WORD_BITS-2:0], bus.user_spi_dout};
      if (done_nxt)            rd_q  <= rx_sr;
    end
  end

  assign bus.rd_data = rd_q;
`else
  logic unused_dout;
  assign unused_dout = bus.user_spi_dout;
  assign bus.rd_data = '0;
`endif

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.user_spi_clk = sclk_q;
  assign bus.user_spi_ss  = ss_q;
  assign bus.user_spi_din = din_q;

endmodule
